// File: rtl/arythcrypt_sequencer.sv
// Command sequencer for the arithmetic crypto core: queues operand/opcode commands,
// issues them one at a time, waits the core's fixed latency and holds each result.
module arythcrypt_sequencer #(
    parameter int DEPTH    = 4,
    parameter int CORE_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [3:0]                 cmd_op,
    input  logic [5:0]                 cmd_a,
    input  logic [5:0]                 cmd_b,
    output logic [7:0]                 core_i1,
    output logic [7:0]                 core_i2,
    output logic [3:0]                 core_ctrl,
    output logic                       core_start,
    input  logic [7:0]                 core_result,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [7:0]                 res_data,
    output logic [3:0]                 res_op,
    output logic                       res_err,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam logic [3:0] OP_ILLEGAL = 4'hF;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic [3:0]    lat_q, lat_d;
    logic [5:0]    a_q, a_d, b_q, b_d;
    logic [3:0]    ctrl_q, ctrl_d;
    logic          res_valid_q, res_valid_d;
    logic [7:0]    res_data_q, res_data_d;
    logic [3:0]    res_op_q, res_op_d;
    logic          res_err_q, res_err_d;
    logic          push, pop, fifo_nempty;
    logic [15:0]   head;

    assign cmd_ready   = (count_q != CW'(DEPTH));
    assign push        = cmd_valid && cmd_ready;
    assign fifo_nempty = (count_q != '0);
    assign head        = mem_q[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        a_d         = a_q;
        b_d         = b_q;
        ctrl_d      = ctrl_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;
        res_err_d   = res_err_q;
        rd_ptr_d    = rd_ptr_q;
        pop         = 1'b0;

        case (state_q)
            S_IDLE: pop = fifo_nempty;
            S_ISSUE: begin
                state_d = S_WAIT;
                lat_d   = 4'(CORE_LAT);
            end
            S_WAIT: begin
                // The edge that takes the counter to zero is the capture edge.
                if (lat_q <= 4'd1) begin
                    lat_d       = 4'd0;
                    res_valid_d = 1'b1;
                    res_data_d  = core_result;
                    res_op_d    = ctrl_q;
                    res_err_d   = 1'b0;
                    state_d     = S_HOLD;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                    pop         = fifo_nempty;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A pop overrides the default next state; illegal opcodes bypass the core.
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            ctrl_d   = head[15:12];
            a_d      = head[11:6];
            b_d      = head[5:0];
            if (head[15:12] == OP_ILLEGAL) begin
                state_d     = S_HOLD;
                res_valid_d = 1'b1;
                res_data_d  = 8'h00;
                res_op_d    = OP_ILLEGAL;
                res_err_d   = 1'b1;
            end else begin
                state_d = S_ISSUE;
            end
        end
    end

    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lat_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            ctrl_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ctrl_q      <= ctrl_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
            res_err_q   <= res_err_d;
        end
    end

    assign core_i1    = {2'b00, a_q};
    assign core_i2    = {2'b00, b_q};
    assign core_ctrl  = ctrl_q;
    assign core_start = (state_q == S_ISSUE);
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_op     = res_op_q;
    assign res_err    = res_err_q;
    assign busy       = (state_q != S_IDLE) || fifo_nempty;
    assign count      = count_q;
endmodule

// File: tb/tb_arythcrypt_sequencer.sv
// Directed bench for arythcrypt_sequencer with a fixed-latency core model that only
// presents a valid result in the cycle just before the expected capture edge.
module tb_arythcrypt_sequencer;
    localparam int DEPTH    = 4;
    localparam int CORE_LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_op;
    logic [5:0] cmd_a, cmd_b;
    logic [7:0] core_i1, core_i2, core_result;
    logic [3:0] core_ctrl;
    logic       core_start;
    logic       res_valid, res_ready;
    logic [7:0] res_data;
    logic [3:0] res_op;
    logic       res_err, busy;
    logic [2:0] count;

    int n_chk  = 0;
    int n_fail = 0;
    int n_start = 0;
    logic [3:0] k;

    logic [7:0] exp_data[$];
    logic [3:0] exp_op[$];
    logic       exp_err[$];

    arythcrypt_sequencer #(.DEPTH(DEPTH), .CORE_LAT(CORE_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .core_i1(core_i1),
        .core_i2(core_i2), .core_ctrl(core_ctrl), .core_start(core_start),
        .core_result(core_result), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_op(res_op), .res_err(res_err), .busy(busy),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] core_fn(logic [3:0] op, logic [5:0] a, logic [5:0] b);
        return ~({2'b00, a} + {2'b00, b}) ^ {4'h0, op};
    endfunction

    // Core model: result is valid only CORE_LAT edges after the start strobe was seen.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  k <= 4'd0;
        else if (core_start)         k <= 4'd1;
        else if (k != 0 && k < 4'd15) k <= k + 4'd1;
    end
    assign core_result = (k == 4'(CORE_LAT)) ? core_fn(core_ctrl, core_i1[5:0], core_i2[5:0]) : 8'h5A;

    always @(negedge clk) if (core_start) n_start++;

    function automatic logic [15:0] tv(int i);
        case (i)
            0: return {4'h1, 6'h01, 6'h02};  1: return {4'h2, 6'h3F, 6'h3F};
            2: return {4'h4, 6'h10, 6'h20};  3: return {4'h5, 6'h2A, 6'h15};
            4: return {4'h6, 6'h00, 6'h3F};  5: return {4'h7, 6'h3C, 6'h03};
            6: return {4'h8, 6'h05, 6'h06};  7: return {4'hF, 6'h11, 6'h22};
            8: return {4'h9, 6'h3E, 6'h01};  9: return {4'hA, 6'h12, 6'h34};
            10: return {4'hB, 6'h07, 6'h08}; 11: return {4'hC, 6'h20, 6'h1F};
            12: return {4'hF, 6'h01, 6'h01};
            default: return {4'hD, 6'(i), 6'h0C};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp();
        exp_data.delete();
        exp_op.delete();
        exp_err.delete();
    endtask

    task automatic push_seq(input int first, input int n);
        logic [15:0] v;
        for (int i = first; i < first + n; i++) begin
            v = tv(i);
            {cmd_op, cmd_a, cmd_b} = v;
            cmd_valid = 1'b1;
            if (cmd_ready) begin
                exp_op.push_back(v[15:12]);
                exp_err.push_back(v[15:12] == 4'hF);
                exp_data.push_back(v[15:12] == 4'hF ? 8'h00 : core_fn(v[15:12], v[11:6], v[5:0]));
            end
            step();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic collect(input int n, input int spacing, input int max_cyc);
        int got = 0;
        int last = 0;
        for (int c = 0; c < max_cyc && got < n; c++) begin
            if (res_valid) begin
                chk("res_data", res_data, exp_data[got]);
                chk("res_op", res_op, exp_op[got]);
                chk("res_err", res_err, exp_err[got]);
                if (spacing != 0 && got > 0) chk("result_spacing", c - last, spacing);
                last = c;
                got++;
            end
            step();
        end
        chk("result_count", got, n);
        chk("idle_after_drain", busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_core_i1"}, core_i1, 0);
        chk({tag, "_core_ctrl"}, core_ctrl, 0);
        chk({tag, "_core_start"}, core_start, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        rst_n = 1'b0;
        cmd_valid = 1'($urandom); cmd_op = 4'($urandom); cmd_a = 6'($urandom);
        cmd_b = 6'($urandom); res_ready = 1'($urandom);
        #2;
        check_reset_outputs("rst");
        chk("rst_res_op", res_op, 0);
        chk("rst_res_err", res_err, 0);
        chk("rst_core_i2", core_i2, 0);
        repeat (3) @(posedge clk);
        check_reset_outputs("rst_clk");
        #1;
        cmd_valid = 1'b0; res_ready = 1'b0;
        rst_n = 1'b1;
        n_start = 0;
        repeat (5) step();
        chk("idle_no_start", n_start, 0);

        // Single command
        res_ready = 1'b1;
        cmd_op = 4'h3; cmd_a = 6'h15; cmd_b = 6'h2A; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("single_count_push", count, 1);
        chk("single_no_start_n", core_start, 0);
        step();
        chk("single_start_n1", core_start, 1);
        chk("single_core_i1", core_i1, 8'h15);
        chk("single_core_i2", core_i2, 8'h2A);
        chk("single_core_ctrl", core_ctrl, 4'h3);
        chk("single_count_pop", count, 0);
        step();
        chk("single_start_n2", core_start, 0);
        chk("single_valid_n2", res_valid, 0);
        step();
        chk("single_valid_n3", res_valid, 0);
        step();
        chk("single_valid_n4", res_valid, 1);
        chk("single_res_data", res_data, 8'hC3);
        chk("single_res_op", res_op, 4'h3);
        chk("single_res_err", res_err, 0);
        step();
        chk("single_consumed", res_valid, 0);
        chk("single_idle", busy, 0);

        // Fill and drain
        clear_exp();
        res_ready = 1'b0;
        push_seq(0, 6);
        chk("fill_accepted", exp_data.size(), 5);
        chk("fill_count", count, 4);
        chk("fill_cmd_ready", cmd_ready, 0);
        step();
        chk("fill_count_hold", count, 4);
        res_ready = 1'b1;
        collect(5, CORE_LAT + 2, 40);

        // Illegal opcode between two legal commands
        clear_exp();
        n_start = 0;
        push_seq(6, 3);
        collect(3, 0, 40);
        chk("illegal_start_count", n_start, 2);

        // Backpressure with two commands queued
        clear_exp();
        res_ready = 1'b0;
        push_seq(9, 3);
        waited = 0;
        while (!res_valid && waited < 10) begin step(); waited++; end
        chk("bp_reached_hold", res_valid, 1);
        n_start = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_res_data", res_data, exp_data[0]);
            chk("bp_res_op", res_op, exp_op[0]);
            chk("bp_count", count, 2);
        end
        chk("bp_no_start", n_start, 0);
        res_ready = 1'b1;
        collect(3, CORE_LAT + 2, 40);

        // Reset mid-WAIT with three commands queued
        clear_exp();
        res_ready = 1'b0;
        push_seq(13, 4);
        chk("mid_count_before", count, 3);
        chk("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        cmd_valid = 1'b1; cmd_op = 4'h2; res_ready = 1'b1;
        step();
        step();
        chk("mid_ignore_push", count, 0);
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        n_start = 0;
        waited = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (res_valid) waited++;
        end
        chk("mid_no_stale_valid", waited, 0);
        chk("mid_no_stale_start", n_start, 0);

        // Asynchronous drop of core_start during ISSUE
        push_seq(17, 1);
        step();
        chk("issue_start_high", core_start, 1);
        rst_n = 1'b0;
        #1;
        chk("issue_start_async_drop", core_start, 0);
        step();
        rst_n = 1'b1;

        // Illegal opcode timing and asynchronous drop of res_valid in HOLD
        res_ready = 1'b0;
        push_seq(12, 1);
        chk("illegal_valid_n", res_valid, 0);
        step();
        chk("illegal_valid_n1", res_valid, 1);
        chk("illegal_err_n1", res_err, 1);
        rst_n = 1'b0;
        #1;
        chk("hold_valid_async_drop", res_valid, 0);
        chk("hold_err_async_drop", res_err, 0);
        step();
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/arythcrypt_sequencer.md
# arythcrypt_sequencer

Command sequencer and result buffer for the arithmetic crypto core. It accepts 6-bit operand pairs plus a 4-bit opcode through a valid/ready port and queues them in a small FIFO. It issues the commands one at a time to the core, waits the core's fixed latency, and captures each result into a held output register with valid/ready backpressure. It sits between the chip-level pin decode and the crypto core, replacing direct pin-to-core wiring.

## Interface
- DEPTH, 4, command FIFO depth; power of two, 2..8
- CORE_LAT, 2, cycles from the core_start cycle to a valid core_result; 1..15
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO not full; equals (count != DEPTH)
- cmd_op  in  4  opcode; 4'hF reserved (illegal)
- cmd_a / cmd_b  in  6  operands
- core_i1 / core_i2  out  8  zero-padded operands to the core: {2'b00, a} / {2'b00, b}
- core_ctrl  out  4  opcode to the core
- core_start  out  1  one-cycle issue strobe
- core_result  in  8  core output
- res_valid  out  1  result held
- res_ready  in  1  consumer accepts the result
- res_data  out  8  captured result
- res_op  out  4  opcode of the result
- res_err  out  1  result is from an illegal opcode
- busy  out  1  FSM not in IDLE, or FIFO not empty
- count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Push occurs when cmd_valid && cmd_ready at a clock edge. There is no push when full; cmd_ready has no combinational dependence on pop.
- FSM states:
  - IDLE: if FIFO is non-empty, pop. Opcode != F goes to ISSUE. Opcode == F goes to HOLD with res_err=1, res_data=0, and no core_start.
  - ISSUE: core_start=1 for this cycle only. Load latency counter with CORE_LAT. Go to WAIT.
  - WAIT: decrement the counter each cycle. When it reaches 0, capture core_result into res_data, set res_op and res_err=0, go to HOLD.
  - HOLD: res_valid=1. On res_ready: if FIFO is non-empty, pop and go to ISSUE (or to HOLD-illegal as in IDLE); otherwise go to IDLE.
- core_i1, core_i2 and core_ctrl are registered at pop. They are held stable through ISSUE, WAIT and HOLD, and until the next pop.
- Results leave in command order. No command is dropped or reordered.
- res_data, res_op and res_err are stable while res_valid=1 and res_ready=0.
- Reset values: all outputs 0 except cmd_ready=1. FIFO pointers and count are 0, FSM is in IDLE, counter is 0.
- While rst_n is low, handshakes are ignored.
- Reset mid-operation (any state) clears immediately and asynchronously:
  - core_start and res_valid drop without waiting for a clock;
  - queued commands are discarded;
  - no stale result appears after release.

## Timing
- Empty FIFO, FSM in IDLE, push at edge N:
  - pop at edge N+1;
  - core_start high between edges N+1 and N+2;
  - capture at edge N+2+CORE_LAT;
  - res_valid high from edge N+2+CORE_LAT.
- Illegal opcode pushed at edge N: res_valid high from edge N+1.
- Sustained throughput with res_ready=1: one result per CORE_LAT+2 cycles, because HOLD→ISSUE is direct.
- count updates at the push/pop edge. Push and pop on the same edge leave count unchanged.
- Full boundary: cmd_ready is low in the cycle after count reaches DEPTH. It returns high the cycle after the first pop.

## Test plan
1. Reset: hold rst_n=0 with random inputs → all outputs 0, cmd_ready=1, count=0. Release and wait 5 cycles idle → core_start is never asserted.
2. Single command (CORE_LAT=2): op=4'h3, a=6'h15, b=6'h2A pushed at edge N; core model drives 8'hC3; res_ready=1 → the following must hold:
   - core_i1=8'h15, core_i2=8'h2A, core_ctrl=4'h3;
   - core_start high for exactly 1 cycle after edge N+1;
   - res_valid after edge N+4 with res_data=8'hC3, res_op=4'h3, res_err=0.
3. Fill and drain (DEPTH=4): res_ready=0, push 6 commands back to back → the following must hold:
   - 5 accepted (1 popped, 4 queued);
   - count=4 and cmd_ready=0;
   - on res_ready=1, all 5 results appear in order, spaced 4 cycles apart.
4. Illegal opcode: push op=4'hF between two legal commands → the following must hold:
   - the middle result has res_err=1, res_data=8'h00, res_op=4'hF;
   - no core_start is issued for it;
   - the surrounding results are correct.
5. Backpressure: res_ready=0 for 10 cycles in HOLD with 2 commands queued → res_data and res_op stay constant, no core_start, count=2 throughout.
6. Reset mid-WAIT: assert rst_n=0 one cycle after core_start with 3 commands queued → outputs clear without a clock, count=0, and no res_valid after release.
